axis_cam_core: RTL

AXIS_CAM_CORE -- requirements
Module: axis_cam_core

---
 rtl/axis_cam_core_if.sv | 18 +
 rtl/axis_cam_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axis_cam_core_if.sv
// Stream interface for the CAM core: one request or response beat per valid/ready handshake.
// user[2:0] carries the opcode on requests and the status on responses.
interface axis_cam_if #(
    parameter int DATA_WIDTH = 4,
    parameter int KEY_WIDTH  = 2,
    parameter int TID_WIDTH  = 4
) ();
    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH*8-1:0]   data;
    logic [KEY_WIDTH*8-1:0]    key;
    logic [2:0]                user;
    logic [TID_WIDTH-1:0]      id;
    logic                      last;

    modport master (output valid, data, key, user, id, last, input ready);
    modport slave  (input valid, data, key, user, id, last, output ready);
endinterface

// File: rtl/axis_cam_core.sv
// Sequential-scan CAM: LOOKUP/INSERT/DELETE walk all entries one per cycle; CLEAR and bad opcodes answer at once.
// Optional AXIS_CAM_CORE_EARLY_EXIT_EN ends the scan on the first key match.
module axis_cam_core #(
    parameter int DATA_WIDTH = 4,
    parameter int KEY_WIDTH  = 2,
    parameter int TID_WIDTH  = 4,
    parameter int DEPTH      = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    axis_cam_if.slave  s_req,
    axis_cam_if.master m_rsp
);

    localparam int DW = DATA_WIDTH * 8;
    localparam int KW = KEY_WIDTH * 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_LOOKUP = 3'b000;
    localparam logic [2:0] OP_INSERT = 3'b001;
    localparam logic [2:0] OP_DELETE = 3'b010;
    localparam logic [2:0] OP_CLEAR  = 3'b011;

    localparam logic [2:0] ST_HIT    = 3'b000;
    localparam logic [2:0] ST_MISS   = 3'b001;
    localparam logic [2:0] ST_FULL   = 3'b010;
    localparam logic [2:0] ST_BADOP  = 3'b011;

    typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

    state_t              r_state, w_next_state;
    logic                w_req_ready, w_rsp_valid, w_accept;

    logic [DEPTH-1:0]    r_valid;
    logic [KW-1:0]       r_key  [DEPTH];
    logic [DW-1:0]       r_data [DEPTH];

    logic [IW-1:0]       r_idx;
    logic                r_hit_found, r_free_found;
    logic [IW-1:0]       r_hit_idx, r_free_idx;

    logic [2:0]          r_req_op;
    logic [KW-1:0]       r_req_key;
    logic [DW-1:0]       r_req_data;
    logic [TID_WIDTH-1:0] r_req_id;
    logic                r_req_last;

    logic [DW-1:0]       r_rsp_data;
    logic [KW-1:0]       r_rsp_key;
    logic [2:0]          r_rsp_user;
    logic [TID_WIDTH-1:0] r_rsp_id;
    logic                r_rsp_last;

    logic                w_cur_hit, w_hit_any, w_free_any, w_last_exam, w_done;
    logic [IW-1:0]       w_hit_idx, w_free_idx;
    logic [2:0]          w_status;

    // Final scan cycle merges the entry under examination with what earlier cycles recorded.
    always_comb begin
        w_cur_hit  = r_valid[r_idx] && (r_key[r_idx] == r_req_key);
        w_hit_any  = r_hit_found || w_cur_hit;
        w_hit_idx  = r_hit_found ? r_hit_idx : r_idx;
        w_free_any = r_free_found || !r_valid[r_idx];
        w_free_idx = r_free_found ? r_free_idx : r_idx;
`ifdef AXIS_CAM_CORE_EARLY_EXIT_EN
        w_last_exam = (r_idx == IW'(DEPTH - 1)) || w_cur_hit;
`else
        w_last_exam = (r_idx == IW'(DEPTH - 1));
`endif
        w_done = (r_state == SEARCH) && w_last_exam;
    end

    always_comb begin
        w_status = ST_BADOP;
        case (r_req_op)
            OP_LOOKUP: w_status = w_hit_any ? ST_HIT : ST_MISS;
            OP_INSERT: w_status = w_hit_any ? ST_HIT : (w_free_any ? ST_MISS : ST_FULL);
            OP_DELETE: w_status = w_hit_any ? ST_HIT : ST_MISS;
            default:   w_status = ST_BADOP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (s_req.valid)
                    w_next_state = (s_req.user[2] || s_req.user == OP_CLEAR) ? RESP : SEARCH;
            end
            SEARCH: if (w_last_exam) w_next_state = RESP;
            RESP: begin
                w_rsp_valid = 1'b1;
                if (m_rsp.ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_accept    = s_req.valid && w_req_ready;
    assign s_req.ready = w_req_ready && i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid      <= '0;
            r_idx        <= '0;
            r_hit_found  <= 1'b0;
            r_hit_idx    <= '0;
            r_free_found <= 1'b0;
            r_free_idx   <= '0;
            r_req_op     <= '0;
            r_req_key    <= '0;
            r_req_data   <= '0;
            r_req_id     <= '0;
            r_req_last   <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_key    <= '0;
            r_rsp_user   <= '0;
            r_rsp_id     <= '0;
            r_rsp_last   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req_op     <= s_req.user;
                r_req_key    <= s_req.key;
                r_req_data   <= s_req.data;
                r_req_id     <= s_req.id;
                r_req_last   <= s_req.last;
                r_idx        <= '0;
                r_hit_found  <= 1'b0;
                r_free_found <= 1'b0;
                if (s_req.user[2] || s_req.user == OP_CLEAR) begin
                    r_rsp_data <= s_req.data;
                    r_rsp_key  <= s_req.key;
                    r_rsp_id   <= s_req.id;
                    r_rsp_last <= s_req.last;
                    r_rsp_user <= s_req.user[2] ? ST_BADOP : ST_HIT;
                    if (!s_req.user[2]) r_valid <= '0;
                end
            end
            if (r_state == SEARCH) begin
                r_idx <= r_idx + 1'b1;
                if (w_cur_hit && !r_hit_found) begin
                    r_hit_found <= 1'b1;
                    r_hit_idx   <= r_idx;
                end
                if (!r_valid[r_idx] && !r_free_found) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_idx;
                end
            end
            if (w_done) begin
                r_rsp_key  <= r_req_key;
                r_rsp_id   <= r_req_id;
                r_rsp_last <= r_req_last;
                r_rsp_user <= w_status;
                r_rsp_data <= (r_req_op == OP_LOOKUP && w_hit_any) ? r_data[w_hit_idx] : r_req_data;
                if (r_req_op == OP_INSERT && !w_hit_any && w_free_any)
                    r_valid[w_free_idx] <= 1'b1;
                if (r_req_op == OP_DELETE && w_hit_any)
                    r_valid[w_hit_idx] <= 1'b0;
            end
        end
    end

    // NOTE: key/data storage has no reset; the valid bits alone decide whether an entry exists.
    always_ff @(posedge i_clk) begin
        if (w_done && r_req_op == OP_INSERT) begin
            if (w_hit_any) begin
                r_data[w_hit_idx] <= r_req_data;
            end else if (w_free_any) begin
                r_key[w_free_idx]  <= r_req_key;
                r_data[w_free_idx] <= r_req_data;
            end
        end
    end

    assign m_rsp.valid = w_rsp_valid;
    assign m_rsp.data  = r_rsp_data;
    assign m_rsp.key   = r_rsp_key;
    assign m_rsp.user  = r_rsp_user;
    assign m_rsp.id    = r_rsp_id;
    assign m_rsp.last  = r_rsp_last;

endmodule
